// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO result registers. Multi-cycle ops hold busy for
// a fixed cycle count, then write HI/LO and pulse done. MTHI/MTLO complete at once.
module mdu #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int         W2    = 2 * WIDTH;
  localparam logic [5:0] MUL_N = 6'(MUL_CYCLES);
  localparam logic [5:0] DIV_N = 6'(DIV_CYCLES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [5:0]       cnt_q;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             accept_run;

  logic signed [W2-1:0] ext_a, ext_b, prod, acc, mul_res;
  logic        [W2-1:0] res_d;

  // Divide-by-zero and the single signed-overflow case are resolved before the
  // arithmetic operators so no undefined division is ever evaluated.
  function automatic logic [W2-1:0] divide(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b,
                                           input logic             sgn);
    logic signed [WIDTH-1:0] sa, sb, q, r;
    sa = $signed(a);
    sb = $signed(b);
    if (b == '0)
      return {a, {WIDTH{1'b1}}};
    else if (sgn && a == {1'b1, {(WIDTH-1){1'b0}}} && b == {WIDTH{1'b1}})
      return {{WIDTH{1'b0}}, a};
    else if (sgn) begin
      q = sa / sb;
      r = sa % sb;
      return {r, q};
    end else
      return {a % b, a / b};
  endfunction

  assign accept_run = reset && start && !busy_q && !op[3];

  always_comb begin
    ext_a = op_q[0] ? $signed({{WIDTH{1'b0}}, a_q}) : $signed({{WIDTH{a_q[WIDTH-1]}}, a_q});
    ext_b = op_q[0] ? $signed({{WIDTH{1'b0}}, b_q}) : $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
    prod  = ext_a * ext_b;
    acc   = $signed({hi_q, lo_q});
    case (op_q[2:1])
      2'b10:   mul_res = acc + prod;
      2'b11:   mul_res = acc - prod;
      default: mul_res = prod;
    endcase
    if (op_q[3:1] == 3'b001)
      res_d = divide(a_q, b_q, ~op_q[0]);
    else
      res_d = mul_res;
  end

  // Operand capture is datapath-only; HI/LO need no capture since they are frozen in RUN.
  always_ff @(posedge clk) begin
    if (accept_run) begin
      op_q <= op;
      a_q  <= A;
      b_q  <= B;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            case (op)
              4'b1000: hi_q <= A;
              4'b1001: lo_q <= A;
              default: begin
                if (!op[3]) begin
                  state_q <= RUN;
                  busy_q  <= 1'b1;
                  cnt_q   <= (op[3:1] == 3'b001) ? DIV_N : MUL_N;
                end
              end
            endcase
          end
        end
        RUN: begin
          cnt_q <= cnt_q - 6'd1;
          if (cnt_q == 6'd1) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            {hi_q, lo_q} <= res_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: driver pushes reference-model results, a monitor
// pops and compares them on every done pulse.
module tb_mdu;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [3:0]  op;
  logic [31:0] A, B, hi, lo;
  logic        busy, done;

  logic        start16;
  logic [3:0]  op16;
  logic [15:0] a16, b16, hi16, lo16;
  logic        busy16, done16;

  int total = 0;
  int bad   = 0;
  logic [63:0] sb[$];
  logic [63:0] mdl;

  mdu dut (.clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
           .busy(busy), .done(done), .hi(hi), .lo(lo));

  mdu #(.WIDTH(16), .MUL_CYCLES(1), .DIV_CYCLES(3)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .op(op16), .A(a16), .B(b16),
    .busy(busy16), .done(done16), .hi(hi16), .lo(lo16));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference model in plain 64-bit arithmetic; division via magnitudes and sign rule.
  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] acc);
    longint      sp, na, nb, ma, mb, q, r;
    logic [63:0] up, p;
    sp = longint'($signed(a)) * longint'($signed(b));
    up = {32'b0, a} * {32'b0, b};
    p  = o[0] ? up : 64'(sp);
    case (o)
      4'd0, 4'd1: return p;
      4'd4, 4'd5: return acc + p;
      4'd6, 4'd7: return acc - p;
      4'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        na = longint'($signed(a));
        nb = longint'($signed(b));
        ma = (na < 0) ? -na : na;
        mb = (nb < 0) ? -nb : nb;
        q  = ma / mb;
        if ((na < 0) != (nb < 0)) q = -q;
        r  = na - q * nb;
        return {r[31:0], q[31:0]};
      end
      4'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      4'd8:    return {a, acc[31:0]};
      4'd9:    return {acc[63:32], a};
      default: return acc;
    endcase
  endfunction

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
      else chk("result", {hi, lo}, sb.pop_front());
    end
  end

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit inject);
    int n;
    n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; A = $urandom; B = $urandom; op = 4'($urandom);
    if (o <= 4'd7) begin
      sb.push_back(model(o, a, b, mdl));
      mdl = model(o, a, b, mdl);
      n = 0;
      while (busy && n < 100) begin
        n++;
        if (inject && n == 3) begin start = 1'b1; op = 4'd0; A = 32'd7; B = 32'd9; end
        if (inject && n == 4) start = 1'b0;
        @(negedge clk);
      end
      chk("busy_cycles", 64'(n), (o[3:1] == 3'b001) ? 64'd10 : 64'd5);
    end else begin
      mdl = model(o, a, b, mdl);
      chk("imm_busy", {63'd0, busy}, 64'd0);
      chk("imm_hilo", {hi, lo}, mdl);
    end
  endtask

  initial begin
    int n;
    logic [31:0] ra, rb;
    logic [3:0]  ro;
    int sel;
    reset = 1'b0; start = 1'b1; op = 4'd8; A = 32'h123; B = 32'd0;
    start16 = 1'b0; op16 = 4'd0; a16 = '0; b16 = '0;
    mdl = '0;
    repeat (3) @(negedge clk);
    start = 1'b0;
    reset = 1'b1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);

    issue(4'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
    chk("req020", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    issue(4'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("req021", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(4'd9, 32'd10, 32'd0, 1'b0);
    issue(4'd8, 32'd0, 32'd0, 1'b0);
    issue(4'd5, 32'hFFFF_FFFF, 32'd2, 1'b0);
    chk("req022", {hi, lo}, 64'h0000_0002_0000_0008);
    issue(4'd3, 32'h1234, 32'd0, 1'b1);
    chk("req023", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
    issue(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
    issue(4'd10, 32'hDEAD, 32'hBEEF, 1'b0);

    start = 1'b1; op = 4'd0; A = 32'd5; B = 32'd6;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (busy && n < 3) begin @(negedge clk); n++; end
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    mdl = '0;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    repeat (8) @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      ro  = 4'($urandom_range(0, 11));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel == 2) begin ra = 32'($urandom_range(0, 40)) - 32'd20; rb = 32'($urandom_range(1, 7)); end
      issue(ro, ra, rb, 1'b0);
    end
    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    start16 = 1'b1; op16 = 4'd1; a16 = 16'hFFFF; b16 = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    start16 = 1'b0; a16 = 16'h0; b16 = 16'h0;
    chk("w16_busy1", {63'd0, busy16}, 64'd1);
    @(negedge clk);
    chk("w16_busy0", {63'd0, busy16}, 64'd0);
    chk("w16_done", {63'd0, done16}, 64'd1);
    chk("w16_hilo", {32'd0, hi16, lo16}, 64'h0000_0000_FFFE_0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
